seq_pattern_gen: RTL and testbench

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

---
 rtl/seq_pattern_gen.sv | 119 +++++++++++
 tb/tb_seq_pattern_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: loads a pattern of up to WIDTH bits and shifts it out
// MSB (bit in_len) first, repeated in_repeat+1 times, with enable-driven pausing.
module seq_pattern_gen #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_pattern,
  input  logic [$clog2(WIDTH)-1:0]   in_len,
  input  logic [3:0]                 in_repeat,
  input  logic                       enable,
  output logic                       out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int LW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_pat, w_pat_nx;
  logic [LW-1:0]    r_len, w_len_nx;
  logic [LW-1:0]    r_idx, w_idx_nx;
  logic [3:0]       r_rep, w_rep_nx;
  logic             r_out, w_out_nx;
  logic             r_out_valid, w_out_valid_nx;
  logic             r_done, w_done_nx;
  logic             w_load;
  logic [LW-1:0]    w_idx_dec;

  assign in_ready  = !rst && (r_state != S_SHIFT);
  assign w_load    = in_valid && in_ready;
  assign w_idx_dec = r_idx - LW'(1);

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign done      = r_done;
  assign busy      = (r_state == S_SHIFT);

  // Next-state and next-output logic; the registered output holds the bit being shown.
  always_comb begin
    w_state_nx     = r_state;
    w_pat_nx       = r_pat;
    w_len_nx       = r_len;
    w_idx_nx       = r_idx;
    w_rep_nx       = r_rep;
    w_out_nx       = 1'b0;
    w_out_valid_nx = 1'b0;
    w_done_nx      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_load) begin
          // The load edge already emits the first bit so it is visible next cycle.
          w_state_nx     = S_SHIFT;
          w_pat_nx       = in_pattern;
          w_len_nx       = in_len;
          w_idx_nx       = in_len;
          w_rep_nx       = in_repeat;
          w_out_nx       = in_pattern[in_len];
          w_out_valid_nx = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (!enable) begin
          w_state_nx = S_SHIFT;
        end else if (r_idx != {LW{1'b0}}) begin
          w_idx_nx       = w_idx_dec;
          w_out_nx       = r_pat[w_idx_dec];
          w_out_valid_nx = 1'b1;
        end else if (r_rep != 4'd0) begin
          w_rep_nx       = r_rep - 4'd1;
          w_idx_nx       = r_len;
          w_out_nx       = r_pat[r_len];
          w_out_valid_nx = 1'b1;
        end else begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pat       <= {WIDTH{1'b0}};
      r_len       <= {LW{1'b0}};
      r_idx       <= {LW{1'b0}};
      r_rep       <= 4'd0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_pat       <= w_pat_nx;
      r_len       <= w_len_nx;
      r_idx       <= w_idx_nx;
      r_rep       <= w_rep_nx;
      r_out       <= w_out_nx;
      r_out_valid <= w_out_valid_nx;
      r_done      <= w_done_nx;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: expected bit stream and done tokens are queued
// at each accepted load; a negedge monitor pops and compares.
module tb_seq_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pattern;
  logic [3:0]  in_len;
  logic [3:0]  in_repeat;
  logic        enable;
  logic        out;
  logic        out_valid;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int sb[$];
  bit rand_en = 1'b0;

  localparam int DONE_TOK = 2;

  seq_pattern_gen #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pattern(in_pattern), .in_len(in_len), .in_repeat(in_repeat),
    .enable(enable), .out(out), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got=timeout/unexpected expected=event at %0t", name, $time);
  endtask

  // Reference: each repetition sends bits len..0 of the pattern, then one done pulse.
  task automatic push_expect(input logic [15:0] pat, input int len, input int rep);
    for (int r = 0; r <= rep; r++)
      for (int i = len; i >= 0; i--)
        sb.push_back(int'(pat[i]));
    sb.push_back(DONE_TOK);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_en) enable = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_load(input logic [15:0] pat, input int len, input int rep, input bit hold);
    bit ok;
    ok = 1'b0;
    in_pattern = pat;
    in_len     = 4'(len);
    in_repeat  = 4'(rep);
    in_valid   = 1'b1;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        push_expect(pat, len, rep);
        ok = 1'b1;
      end
      step();
    end
    if (!ok) fail_now("load_wait");
    if (!hold) in_valid = 1'b0;
    in_pattern = 16'($urandom);
    in_len     = 4'($urandom);
    in_repeat  = 4'($urandom);
  endtask

  task automatic drain();
    for (int c = 0; c < 5000 && sb.size() != 0; c++) step();
    if (sb.size() != 0) fail_now("drain");
    sb.delete();
    step();
    step();
  endtask

  // n consecutive valid bits straight after the load, then the done cycle.
  task automatic run_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("valid_run", int'(out_valid), 1);
      chk("ready_in_shift", int'(in_ready), 0);
    end
    @(negedge clk);
    chk("done_pulse", int'(done), 1);
    chk("ready_in_done", int'(in_ready), 1);
  endtask

  // Monitor: compare every presented bit and every done pulse against the queue.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sb.size() == 0 || sb[0] == DONE_TOK) begin
          fail_now("extra_bit");
        end else begin
          e = sb.pop_front();
          chk("bit", int'(out), e);
        end
        chk("busy_when_valid", int'(busy), 1);
      end else begin
        chk("out_zero_idle", int'(out), 0);
      end
      if (done) begin
        if (sb.size() != 0 && sb[0] == DONE_TOK) begin
          e = sb.pop_front();
          chk("done_token", e, DONE_TOK);
        end else begin
          fail_now("unexpected_done");
        end
        chk("done_no_valid", int'(out_valid), 0);
        chk("done_not_busy", int'(busy), 0);
      end
    end
  end

  initial begin
    logic [15:0] p;
    int l, r;
    rst = 1'b1; in_valid = 1'b1; in_pattern = 16'hFFFF; in_len = 4'd15;
    in_repeat = 4'd0; enable = 1'b1;

    // Reset held with a pending load request.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_out", int'(out), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(in_ready), 1);
    chk("post_rst_busy", int'(busy), 0);
    step();

    // Single 4-bit transfer.
    do_load(16'h000B, 3, 0, 1'b0);
    run_check(4);
    drain();

    // Repeated 2-bit pattern, no gaps.
    do_load(16'h0002, 1, 2, 1'b0);
    run_check(6);
    drain();

    // Pause for two cycles after the second bit.
    do_load(16'h000D, 3, 0, 1'b0);
    step();
    enable = 1'b0;
    step();
    @(negedge clk);
    chk("pause1_valid", int'(out_valid), 0);
    chk("pause1_busy", int'(busy), 1);
    step();
    enable = 1'b1;
    @(negedge clk);
    chk("pause2_valid", int'(out_valid), 0);
    chk("pause2_busy", int'(busy), 1);
    drain();

    // Back-to-back full-width transfers with in_valid held.
    do_load(16'hA5C3, 15, 0, 1'b1);
    in_pattern = 16'h3C96; in_len = 4'd15; in_repeat = 4'd0;
    run_check(16);
    push_expect(16'h3C96, 15, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_first_bit", int'(out_valid), 1);
    drain();

    // Abort with reset during the third bit.
    do_load(16'h00B7, 7, 0, 1'b0);
    step();
    step();
    rst = 1'b1;
    @(posedge clk);
    sb.delete();
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out", int'(out), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    for (int k = 0; k < 4; k++) step();
    do_load(16'h0135, 7, 1, 1'b0);
    drain();

    // Randomized transfers with random enable, gaps and back-to-back loads.
    rand_en = 1'b1;
    for (int t = 0; t < 30; t++) begin
      p = 16'($urandom);
      l = $urandom_range(0, 15);
      r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      do_load(p, l, r, ($urandom_range(0, 2) == 0) && (t != 29));
      if (!in_valid) for (int g = 0; g < $urandom_range(0, 3); g++) step();
    end
    in_valid = 1'b0;
    drain();
    rand_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
